// File: rtl/mode_control_unit.sv
// Start/stop, display-mode and clear button controller for a score display.
// Ports: i_clk, i_rst_n, raw buttons i_start_stop/i_mode_next/i_clr;
// outputs o_cnt_en, o_rst, o_disp_en, o_running (all registered).
// Optional DISP_TIMEOUT_EN: o_disp_en returns to 0 after HOLD_CYCLES idle.
module mode_control_unit #(
  parameter int N_MODES     = 3,
  parameter int DISP_W      = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_stop,
  input  logic              i_mode_next,
  input  logic              i_clr,
  output logic              o_cnt_en,
  output logic              o_rst,
  output logic [DISP_W-1:0] o_disp_en,
  output logic              o_running
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    RUN,
    PAUSE
  } state_t;

  // bit 0 = start_stop, bit 1 = mode_next, bit 2 = clr
  logic [2:0] raw;
  logic [2:0] s1_q;
  logic [2:0] s2_q;
  logic [2:0] press;

  assign raw = {i_clr, i_mode_next, i_start_stop};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [DCW-1:0] cnt_q;
    logic [DCW-1:0] cnt_d;
    logic           stab_q;
    logic           stab_d;
    logic           press_q;
    logic           press_d;

    // A differing level must persist DEB_CYCLES samples to be accepted.
    always_comb begin
      cnt_d   = '0;
      stab_d  = stab_q;
      press_d = 1'b0;
      if (s2_q[g] != stab_q) begin
        if (cnt_q == DCW'(DEB_CYCLES - 1)) begin
          stab_d  = s2_q[g];
          press_d = s2_q[g];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q   <= '0;
        stab_q  <= 1'b0;
        press_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        stab_q  <= stab_d;
        press_q <= press_d;
      end
    end

    assign press[g] = press_q;
  end

  logic ss_p;
  logic mode_p;
  logic clr_p;

  assign ss_p   = press[0];
  assign mode_p = press[1];
  assign clr_p  = press[2];

  state_t            state_q;
  state_t            state_d;
  logic [DISP_W-1:0] disp_q;
  logic [DISP_W-1:0] disp_d;
  logic [DISP_W-1:0] disp_inc;
  logic              tmo;

  assign disp_inc = (disp_q == DISP_W'(N_MODES - 1)) ?
                    '0 : disp_q + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: state_d = IDLE;
      IDLE: begin
        if (clr_p)     state_d = CLEAR;
        else if (ss_p) state_d = RUN;
      end
      RUN: begin
        if (clr_p)     state_d = CLEAR;
        else if (ss_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_p)     state_d = CLEAR;
        else if (ss_p) state_d = RUN;
      end
    endcase
  end

`ifdef DISP_TIMEOUT_EN
  localparam int HCW = $clog2(HOLD_CYCLES);

  logic [HCW-1:0] tmr_q;
  logic [HCW-1:0] tmr_d;

  assign tmo = (disp_q != '0) && !mode_p &&
               (tmr_q == HCW'(HOLD_CYCLES - 1));

  always_comb begin
    tmr_d = tmr_q + 1'b1;
    if (mode_p || (disp_d == '0)) tmr_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tmr_q <= '0;
    else          tmr_q <= tmr_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // Entering CLEAR wins over a same-cycle mode press.
  always_comb begin
    disp_d = disp_q;
    if (state_d == CLEAR) disp_d = '0;
    else if (mode_p)      disp_d = disp_inc;
    else if (tmo)         disp_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= CLEAR;
      disp_q    <= '0;
      o_rst     <= 1'b1;
      o_cnt_en  <= 1'b0;
      o_running <= 1'b0;
    end else begin
      state_q   <= state_d;
      disp_q    <= disp_d;
      o_rst     <= (state_d == CLEAR);
      o_cnt_en  <= (state_d == RUN);
      o_running <= (state_d == RUN);
    end
  end

  assign o_disp_en = disp_q;

endmodule

// File: tb/tb_mode_control_unit.sv
// Directed bench for mode_control_unit.
// DEB_CYCLES=4, HOLD_CYCLES=8, N_MODES=3.
module tb_mode_control_unit;

  logic       clk;
  logic       rst_n;
  logic       ss;
  logic       mode;
  logic       clr;
  logic       cnt_en;
  logic       orst;
  logic [1:0] disp;
  logic       running;

  int checks;
  int failures;

  mode_control_unit #(
    .N_MODES(3),
    .DISP_W(2),
    .DEB_CYCLES(4),
    .HOLD_CYCLES(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start_stop(ss),
    .i_mode_next(mode),
    .i_clr(clr),
    .o_cnt_en(cnt_en),
    .o_rst(orst),
    .o_disp_en(disp),
    .o_running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    mode = 1'b1;
    step(4);
    mode = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ss = 1'b0;
    mode = 1'b0;
    clr = 1'b0;
    step(3);
    checks++;
    if (orst !== 1'b1) begin
      failures++;
      $display("FAIL rst_orst got=%b exp=1", orst);
    end
    checks++;
    if (cnt_en !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL rst_run got=%b%b exp=00", cnt_en, running);
    end
    checks++;
    if (disp !== 2'd0) begin
      failures++;
      $display("FAIL rst_disp got=%0d exp=0", disp);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (orst !== 1'b0) begin
      failures++;
      $display("FAIL rel_orst got=%b exp=0", orst);
    end
    checks++;
    if (cnt_en !== 1'b0 || disp !== 2'd0) begin
      failures++;
      $display("FAIL rel_out got=%b/%0d exp=0/0", cnt_en, disp);
    end
  endtask

  task automatic test_start_stop();
    ss = 1'b1;
    step(6);
    checks++;
    if (cnt_en !== 1'b0) begin
      failures++;
      $display("FAIL ss_early got=%b exp=0", cnt_en);
    end
    step(1);
    checks++;
    if (cnt_en !== 1'b1 || running !== 1'b1) begin
      failures++;
      $display("FAIL ss_run got=%b%b exp=11", cnt_en, running);
    end
    step(3);
    ss = 1'b0;
    step(10);
    checks++;
    if (cnt_en !== 1'b1) begin
      failures++;
      $display("FAIL ss_release got=%b exp=1", cnt_en);
    end
    ss = 1'b1;
    step(7);
    checks++;
    if (cnt_en !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL ss_pause got=%b%b exp=00", cnt_en, running);
    end
    step(3);
    ss = 1'b0;
    step(10);
    ss = 1'b1;
    step(7);
    checks++;
    if (cnt_en !== 1'b1) begin
      failures++;
      $display("FAIL ss_resume got=%b exp=1", cnt_en);
    end
    step(3);
    ss = 1'b0;
    step(10);
  endtask

  task automatic test_glitch();
    ss = 1'b1;
    step(3);
    ss = 1'b0;
    step(12);
    checks++;
    if (cnt_en !== 1'b1 || running !== 1'b1) begin
      failures++;
      $display("FAIL glitch got=%b%b exp=11", cnt_en, running);
    end
  endtask

  task automatic test_mode_wrap();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd1, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      press_mode();
      checks++;
      if (disp !== exp_seq[i]) begin
        failures++;
        $display("FAIL mode_%0d got=%0d exp=%0d", i, disp, exp_seq[i]);
      end
    end
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL mode_state got=%b exp=1", running);
    end
  endtask

  task automatic test_clr_priority();
    clr = 1'b1;
    ss = 1'b1;
    step(7);
    checks++;
    if (orst !== 1'b1 || cnt_en !== 1'b0) begin
      failures++;
      $display("FAIL clr_pulse got=%b%b exp=10", orst, cnt_en);
    end
    step(1);
    checks++;
    if (orst !== 1'b0) begin
      failures++;
      $display("FAIL clr_end got=%b exp=0", orst);
    end
    checks++;
    if (cnt_en !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL clr_idle got=%b%b exp=00", cnt_en, running);
    end
    checks++;
    if (disp !== 2'd0) begin
      failures++;
      $display("FAIL clr_disp got=%0d exp=0", disp);
    end
    step(2);
    clr = 1'b0;
    ss = 1'b0;
    step(10);
  endtask

  task automatic test_timeout();
    press_mode();
    press_mode();
`ifdef DISP_TIMEOUT_EN
    step(6);
    checks++;
    if (disp !== 2'd2) begin
      failures++;
      $display("FAIL tmo_hold got=%0d exp=2", disp);
    end
    step(1);
    checks++;
    if (disp !== 2'd0) begin
      failures++;
      $display("FAIL tmo_ret got=%0d exp=0", disp);
    end
`else
    step(20);
    checks++;
    if (disp !== 2'd2) begin
      failures++;
      $display("FAIL hold_disp got=%0d exp=2", disp);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_d;
`ifdef DISP_TIMEOUT_EN
    exp_d = 2'd1;
`else
    exp_d = 2'd0;
`endif
    ss = 1'b1;
    mode = 1'b1;
    step(4);
    ss = 1'b0;
    mode = 1'b0;
    step(3);
    checks++;
    if (running !== 1'b1 || cnt_en !== 1'b1) begin
      failures++;
      $display("FAIL b2b_run got=%b%b exp=11", running, cnt_en);
    end
    checks++;
    if (disp !== exp_d) begin
      failures++;
      $display("FAIL b2b_disp got=%0d exp=%0d", disp, exp_d);
    end
    step(6);
  endtask

  task automatic test_reset_mid_run();
    ss = 1'b1;
    step(2);
    rst_n = 1'b0;
    step(2);
    checks++;
    if (orst !== 1'b1 || cnt_en !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got=%b%b%b exp=100", orst, cnt_en, running);
    end
    checks++;
    if (disp !== 2'd0) begin
      failures++;
      $display("FAIL mid_disp got=%0d exp=0", disp);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (orst !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL mid_rel got=%b%b exp=00", orst, running);
    end
    step(5);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL mid_early got=%b exp=0", running);
    end
    step(1);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL mid_held got=%b exp=1", running);
    end
    ss = 1'b0;
    step(10);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL mid_release got=%b exp=1", running);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_start_stop();
    test_glitch();
    test_mode_wrap();
    test_clr_priority();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
